// File: rtl/proj_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : proj_select_ctrl
//  Purpose  : Shares the user I/O bank between NPROJ user designs. Firmware
//             writes a project index and an enable bit over Wishbone. The
//             block then runs a safe handover:
//               1. gate all user outputs,
//               2. hold every project in reset,
//               3. switch the multiplexer select,
//               4. release only the chosen project after a reset window.
//  Ports    : wb_clk_i / wb_rst_i        clock, synchronous active-high reset
//             wbs_*                      Wishbone classic slave, 16-byte window
//             proj_sel  [SW-1:0]         multiplexer select
//             proj_rst  [NPROJ-1:0]      per-project reset, active-high
//             io_en                      selected project may drive mprj_io
//             busy                       handover sequence in progress
//  Registers: 0x0 CTRL   rw  [SW-1:0] sel (lane 0), [8] enable (lane 1)
//             0x4 STATUS ro  [SW-1:0] proj_sel, [9:8] state, [10] busy,
//                            [11] err
//             0x8, 0xC       read 0, writes ignored, still acked
//  Revision : 1.0  initial release
// ============================================================================
module proj_select_ctrl #(
    parameter int          NPROJ       = 8,
    parameter int          GATE_CYCLES = 4,
    parameter int          RST_CYCLES  = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    localparam int         SW          = (NPROJ > 1) ? $clog2(NPROJ) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [SW-1:0]    proj_sel,
    output logic [NPROJ-1:0] proj_rst,
    output logic             io_en,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GATE  = 2'd1,
        ST_RESET = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int c_max_cnt = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
    localparam logic [c_cnt_w-1:0] c_gate_last = c_cnt_w'(GATE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rst_last  = c_cnt_w'(RST_CYCLES - 1);

    state_t             state_q,    state_d;
    logic [c_cnt_w-1:0] cnt_q,      cnt_d;
    logic [SW-1:0]      ctrl_sel_q, ctrl_sel_d;
    logic               ctrl_en_q,  ctrl_en_d;
    logic               err_q,      err_d;
    logic [SW-1:0]      proj_sel_q, proj_sel_d;
    logic [NPROJ-1:0]   proj_rst_q, proj_rst_d;
    logic               io_en_q,    io_en_d;
    logic               busy_q,     busy_d;
    logic               ack_q,      ack_d;
    logic [31:0]        dat_q,      dat_d;

    logic w_in_win;
    logic w_acc;
    logic w_ctrl_wr;
    logic w_sel_bad;
    logic w_mismatch;

    // Byte-lane bits that carry no register content.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_sel_i[3:2]};

    // ------------------------------------------------------------------
    // Wishbone decode and register file
    // ------------------------------------------------------------------
    always_comb begin
        w_in_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        // Holding ack low for a cycle between accesses forbids back-to-back
        // acks even when the master keeps its strobe raised.
        w_acc     = wbs_cyc_i & wbs_stb_i & w_in_win & ~ack_q;
        w_ctrl_wr = w_acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
        // The whole lane-0 byte is range-checked, so an index such as 0xA
        // is rejected instead of being truncated into a legal select.
        w_sel_bad = wbs_sel_i[0] & (wbs_dat_i[7:0] >= 8'(NPROJ));
    end

    always_comb begin
        ctrl_sel_d = ctrl_sel_q;
        ctrl_en_d  = ctrl_en_q;
        err_d      = err_q;
        ack_d      = w_acc;
        dat_d      = '0;

        if (w_ctrl_wr) begin
            if (w_sel_bad) begin
                err_d = 1'b1;
            end else begin
                if (wbs_sel_i[0]) ctrl_sel_d = wbs_dat_i[SW-1:0];
                if (wbs_sel_i[1]) ctrl_en_d  = wbs_dat_i[8];
                err_d = 1'b0;
            end
        end

        if (w_acc && !wbs_we_i) begin
            case (wbs_adr_i[3:2])
                2'd0: begin
                    dat_d[SW-1:0] = ctrl_sel_q;
                    dat_d[8]      = ctrl_en_q;
                end
                2'd1: begin
                    dat_d[SW-1:0] = proj_sel_q;
                    dat_d[9:8]    = state_q;
                    dat_d[10]     = busy_q;
                    dat_d[11]     = err_q;
                end
                default: dat_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handover sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        proj_sel_d = proj_sel_q;
        w_mismatch = !ctrl_en_q || (ctrl_sel_q != proj_sel_q);

        case (state_q)
            ST_OFF: begin
                if (ctrl_en_q) begin
                    state_d = ST_GATE;
                    cnt_d   = '0;
                end
            end
            ST_GATE: begin
                if (cnt_q == c_gate_last) begin
                    if (!ctrl_en_q) begin
                        state_d = ST_OFF;
                    end else begin
                        // The only place the mux select moves: outputs are
                        // gated and every project is held in reset.
                        proj_sel_d = ctrl_sel_q;
                        state_d    = ST_RESET;
                        cnt_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q == c_rst_last) begin
                    // CTRL may have been rewritten while sequencing; the
                    // latest value is honoured by restarting the handover.
                    if (w_mismatch) begin
                        state_d = ST_GATE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_RUN: begin
                if (w_mismatch) begin
                    state_d = ST_GATE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside it and line up with the state they describe.
        io_en_d    = (state_d == ST_RUN);
        busy_d     = (state_d == ST_GATE) || (state_d == ST_RESET);
        proj_rst_d = '1;
        if (state_d == ST_RUN) proj_rst_d[proj_sel_d] = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            ctrl_sel_q <= '0;
            ctrl_en_q  <= 1'b0;
            err_q      <= 1'b0;
            proj_sel_q <= '0;
            proj_rst_q <= '1;
            io_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_sel_q <= ctrl_sel_d;
            ctrl_en_q  <= ctrl_en_d;
            err_q      <= err_d;
            proj_sel_q <= proj_sel_d;
            proj_rst_q <= proj_rst_d;
            io_en_q    <= io_en_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign proj_sel  = proj_sel_q;
    assign proj_rst  = proj_rst_q;
    assign io_en     = io_en_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_proj_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proj_select_ctrl
//  Purpose  : Self-checking bench for proj_select_ctrl. A cycle-level
//             reference model of the register map and handover timeline is
//             compared with every DUT output each cycle, alongside directed
//             checks of the documented scenarios and a random traffic phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_proj_select_ctrl;

    localparam int          NPROJ = 8;
    localparam int          GATE  = 4;
    localparam int          RSTC  = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          SW    = 3;

    localparam int P_OFF = 0, P_GATE = 1, P_RESET = 2, P_RUN = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_i;
    logic              ack;
    logic [31:0]       dat_o;
    logic [SW-1:0]     proj_sel;
    logic [NPROJ-1:0]  proj_rst;
    logic              io_en;
    logic              busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_phase, m_left, m_sel, m_en, m_err, m_psel, m_ack;
    logic [31:0] m_dat;

    always #5 clk = ~clk;

    proj_select_ctrl #(
        .NPROJ       (NPROJ),
        .GATE_CYCLES (GATE),
        .RST_CYCLES  (RSTC),
        .BASE_ADDR   (BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .proj_sel  (proj_sel),
        .proj_rst  (proj_rst),
        .io_en     (io_en),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, applied to the inputs that
    // were present before the edge.
    task automatic model_edge();
        logic        acc;
        logic [31:0] rd;
        int          off;
        int          nsel;
        if (rst) begin
            m_phase = P_OFF; m_left = 0; m_sel = 0; m_en = 0; m_err = 0;
            m_psel = 0; m_ack = 0; m_dat = 32'h0;
            return;
        end
        acc = cyc && stb && (adr[31:4] == BASE[31:4]) && (m_ack == 0);
        off = int'(adr[3:2]);
        rd  = 32'h0;
        if (acc && !we) begin
            if (off == 0)
                rd = 32'(m_sel) | (32'(m_en) << 8);
            else if (off == 1)
                rd = 32'(m_psel) | (32'(m_phase) << 8)
                   | (32'((m_phase == P_GATE || m_phase == P_RESET) ? 1 : 0) << 10)
                   | (32'(m_err) << 11);
        end
        // Handover timeline, driven by the CTRL contents before this edge.
        case (m_phase)
            P_OFF:   if (m_en != 0) begin m_phase = P_GATE; m_left = GATE; end
            P_GATE:  if (m_left > 1) m_left--;
                     else if (m_en == 0) m_phase = P_OFF;
                     else begin m_psel = m_sel; m_phase = P_RESET; m_left = RSTC; end
            P_RESET: if (m_left > 1) m_left--;
                     else if (m_en == 0 || m_sel != m_psel) begin m_phase = P_GATE; m_left = GATE; end
                     else m_phase = P_RUN;
            default: if (m_en == 0 || m_sel != m_psel) begin m_phase = P_GATE; m_left = GATE; end
        endcase
        if (acc && we && off == 0) begin
            nsel = int'(dat_i[7:0]);
            if (sel[0] && nsel >= NPROJ) m_err = 1;
            else begin
                if (sel[0]) m_sel = nsel;
                if (sel[1]) m_en = int'(dat_i[8]);
                m_err = 0;
            end
        end
        m_ack = acc ? 1 : 0;
        m_dat = rd;
    endtask

    task automatic step();
        logic [7:0] e_rst;
        @(posedge clk);
        model_edge();
        #1;
        e_rst = 8'hFF;
        if (m_phase == P_RUN) e_rst[m_psel] = 1'b0;
        check("ack",      32'(ack),      32'(m_ack));
        check("dat_o",    dat_o,         m_dat);
        check("proj_sel", 32'(proj_sel), 32'(m_psel));
        check("proj_rst", 32'(proj_rst), 32'(e_rst));
        check("io_en",    32'(io_en),    (m_phase == P_RUN) ? 32'd1 : 32'd0);
        check("busy",     32'(busy),     (m_phase == P_GATE || m_phase == P_RESET) ? 32'd1 : 32'd0);
    endtask

    task automatic wb_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    endtask

    // Request at T; returns at T+2 (after the ack cycle and one idle cycle).
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        step();
        wb_idle();
        check("wr_ack", 32'(ack), 32'd1);
        step();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1; dat_i = 32'h0;
        step();
        wb_idle();
        check("rd_ack", 32'(ack), 32'd1);
        d = dat_o;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        bit          seen;

        m_phase = P_OFF; m_left = 0; m_sel = 0; m_en = 0; m_err = 0;
        m_psel = 0; m_ack = 0; m_dat = 32'h0;
        wb_idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_proj_rst", 32'(proj_rst), 32'hFF);
        check("reset_io_en",    32'(io_en),    32'd0);
        check("reset_proj_sel", 32'(proj_sel), 32'd0);
        wb_read(BASE + 32'h4, rd);
        check("reset_status", rd, 32'h0);

        // Enable project 3
        wb_write(BASE, 32'h103, 4'hF);
        for (int c = 2; c <= 21; c++) begin
            check("en_io_gated", 32'(io_en), 32'd0);
            if (c == 5) check("en_sel_old", 32'(proj_sel), 32'd0);
            if (c == 6) check("en_sel_new", 32'(proj_sel), 32'd3);
            step();
        end
        check("en_run_io",  32'(io_en),    32'd1);
        check("en_run_rst", 32'(proj_rst), 32'hF7);

        // Switch to project 5 while running
        wb_write(BASE, 32'h105, 4'hF);
        for (int c = 2; c <= 21; c++) begin
            check("sw_io_gated", 32'(io_en), 32'd0);
            check("sw_sel", 32'(proj_sel), (c <= 5) ? 32'd3 : 32'd5);
            step();
        end
        check("sw_run_io",  32'(io_en),    32'd1);
        check("sw_run_rst", 32'(proj_rst), 32'hDF);

        // Rewrite during RESET: sel=2 then sel=6
        wb_write(BASE, 32'h102, 4'hF);
        for (int c = 2; c < 10; c++) begin
            check("mid_no_sel2", 32'(io_en === 1'b1 && proj_sel === 3'd2), 32'd0);
            step();
        end
        check("mid_in_reset", 32'(proj_sel), 32'd2);
        wb_write(BASE, 32'h106, 4'hF);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            check("mid_no_sel2", 32'(io_en === 1'b1 && proj_sel === 3'd2), 32'd0);
            if (io_en === 1'b1) seen = 1'b1;
            else begin step(); n++; end
        end
        check("mid_run_reached", 32'(io_en), 32'd1);
        check("mid_run_delay",   32'(n),     32'd30);
        check("mid_sel",         32'(proj_sel), 32'd6);
        check("mid_rst",         32'(proj_rst), 32'hBF);

        // Out-of-range index, then lane-restricted write
        wb_write(BASE, 32'h10A, 4'hF);
        wb_read(BASE, rd);
        check("bad_ctrl", rd, 32'h106);
        wb_read(BASE + 32'h4, rd);
        check("bad_status", rd, 32'hB06);
        wb_write(BASE, 32'h100, 4'b0010);
        wb_read(BASE, rd);
        check("lane_ctrl", rd, 32'h106);
        wb_read(BASE + 32'h4, rd);
        check("lane_status", rd, 32'h306);
        check("lane_io_en", 32'(io_en), 32'd1);

        // Reset in the middle of GATE
        wb_write(BASE, 32'h103, 4'hF);
        check("mr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_proj_rst", 32'(proj_rst), 32'hFF);
        check("mr_proj_sel", 32'(proj_sel), 32'd0);
        check("mr_busy_off", 32'(busy),     32'd0);
        wb_read(BASE, rd);
        check("mr_ctrl", rd, 32'h0);

        // Enable project 1, then disable from RUN
        wb_write(BASE, 32'h101, 4'hF);
        n = 0;
        while (io_en !== 1'b1 && n < 40) begin step(); n++; end
        check("dis_pre_rst", 32'(proj_rst), 32'hFD);
        wb_write(BASE, 32'h000, 4'hF);
        for (int c = 2; c <= 5; c++) begin
            check("dis_gated", 32'(io_en), 32'd0);
            check("dis_busy",  32'(busy),  32'd1);
            step();
        end
        check("dis_off_busy", 32'(busy),     32'd0);
        check("dis_off_rst",  32'(proj_rst), 32'hFF);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            wb_idle();
            rst = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                adr = BASE; we = 1'b1; cyc = 1'b1; stb = 1'b1;
                dat_i = $urandom;
                dat_i[7:0] = 8'($urandom_range(0, 11));
                dat_i[8] = ($urandom_range(0, 4) != 0);
                sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end else if (r < 5) begin
                adr = BASE + (32'($urandom_range(1, 3)) << 2);
                we = 1'b1; cyc = 1'b1; stb = 1'b1; dat_i = $urandom; sel = 4'($urandom);
            end else if (r < 25) begin
                adr = BASE + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
                cyc = 1'b1; stb = 1'b1;
            end else if (r < 29) begin
                adr = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 : 32'h2000_0004;
                we = 1'($urandom); cyc = 1'b1; stb = 1'b1; dat_i = $urandom; sel = 4'hF;
            end else if (r < 32) begin
                adr = BASE; cyc = 1'($urandom); stb = ~cyc; we = 1'b1; dat_i = 32'h101; sel = 4'hF;
            end else if (r == 32 && $urandom_range(0, 9) == 0) begin
                rst = 1'b1;
            end
            step();
        end
        wb_idle();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proj_select_ctrl.md
# proj_select_ctrl

Wishbone-configured controller that shares the user I/O bank (mprj_io) between NPROJ independent user designs in the multi-project wrapper. Firmware writes a project index and enable bit; the block sequences a safe handover: gate all user outputs, hold every project in reset, switch the multiplexer select, release only the chosen project after a programmable reset window. It drives the select/reset/gate inputs of the project multiplexer and exposes a status register for firmware polling.

## Interface
- NPROJ, 8: number of user projects (2..16); SW = clog2(NPROJ)
- GATE_CYCLES, 4: cycles outputs stay gated before select changes (>=1)
- RST_CYCLES, 16: cycles the new project is held in reset after select changes (>=1)
- BASE_ADDR, 32'h3000_0000: Wishbone base; 16-byte window

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic strobes
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- proj_sel  out  SW  multiplexer select
- proj_rst  out  NPROJ  per-project reset, active-high
- io_en  out  1  1 = selected project may drive mprj_io outputs
- busy  out  1  handover sequence in progress

## Operation
- Registers (offset): 0x0 CTRL rw: [SW-1:0] sel (lane 0), [8] enable (lane 1). 0x4 STATUS ro: [SW-1:0] active proj_sel, [9:8] state code, [10] busy, [11] err. 0x8/0xC: read 0, writes ignored, still acked.
- Write to CTRL with sel >= NPROJ: whole write discarded, err set; err clears on next accepted CTRL write.
- Lane rule: unselected lanes leave their CTRL bits unchanged.
- FSM states (code): OFF(0), GATE(1), RESET(2), RUN(3).
- OFF: io_en=0, proj_rst all 1, busy=0. Go GATE when CTRL.enable=1.
- GATE: io_en=0, proj_rst all 1, busy=1, counts GATE_CYCLES. On exit: if enable=0 -> OFF; else load proj_sel<=CTRL.sel, go RESET.
- RESET: io_en=0, proj_rst all 1, busy=1, counts RST_CYCLES. On exit: if enable=0 or CTRL.sel != proj_sel -> GATE (restart); else RUN.
- RUN: io_en=1, proj_rst[proj_sel]=0, all others 1, busy=0. Go GATE when enable=0 or CTRL.sel != proj_sel.
- CTRL writes during GATE/RESET are accepted immediately; the sequence is not aborted, only re-evaluated at RESET exit (latest value wins). Rewriting identical sel/enable in RUN causes no transition.
- proj_sel changes only on GATE->RESET edge; never while io_en=1.

## Timing
- Reset values: state OFF, CTRL=0, err=0, proj_sel=0, proj_rst all 1, io_en=0, busy=0, wbs_ack_o=0, wbs_dat_o=0. wb_rst_i asserted mid-sequence returns to these values at the next edge.
- Wishbone: request (cyc&stb, address in window) at cycle T -> ack high during T+1 only, dat_o valid with it; CTRL updates on the edge that raises ack. No back-to-back ack: ack requires ack low in prior cycle. Out-of-window addresses: never acked.
- Write at T causing a change from OFF/RUN: FSM enters GATE at T+2 (io_en low from T+2), RESET at T+2+GATE_CYCLES, RUN at T+2+GATE_CYCLES+RST_CYCLES. Defaults: RUN at T+22.
- Disable from RUN: io_en low at T+2, OFF at T+2+GATE_CYCLES.
- All outputs registered; no combinational path from Wishbone inputs to proj_sel/proj_rst/io_en.

## Test plan
- Reset: hold wb_rst_i 3 cycles -> proj_rst=8'hFF, io_en=0, proj_sel=0, STATUS reads 0.
- Enable: write CTRL=0x103 at T -> ack at T+1, io_en=0 through T+21, proj_sel=3 from T+6, RUN at T+22 with proj_rst=8'hF7, io_en=1.
- Switch in RUN: write CTRL=0x105 -> io_en falls 2 cycles after request, proj_sel stays 3 for 4 gated cycles, then 5; RUN after 20 more cycles, proj_rst=8'hDF.
- Mid-sequence rewrite: write sel=2 then, during RESET, sel=6 -> RESET exit re-enters GATE, ends RUN with proj_sel=6; io_en never high with proj_sel=2.
- Bad index / lanes: NPROJ=8, write CTRL=0x10A -> CTRL unchanged, STATUS.err=1; write 0x100 with wbs_sel_i=4'b0010 -> only enable bit updated, err cleared.
- Reset mid-sequence and disable: assert wb_rst_i during GATE -> OFF next edge; in RUN write CTRL=0x000 -> OFF after GATE_CYCLES, proj_rst=8'hFF.
